// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux tree channel scanner.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    localparam int DEF_LEVELS     = 3;
    localparam int DEF_SEL_W      = 3;
    localparam int DEF_NUM_CH     = 48;
    localparam int DEF_BBM_CYC    = 2;
    localparam int DEF_SETTLE_CYC = 8;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational search for the next channel of a (possibly wrapping) scan range.
// With SCAN_MASK_EN defined, only channels whose mask bit is set are eligible.
module mux_scan_next_ch
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = clog2_min1(DEF_NUM_CH)
) (
    input  logic [CH_W-1:0]   first,
    input  logic [CH_W-1:0]   last,
    input  logic [CH_W-1:0]   cur,
    input  logic              restart,
`ifdef SCAN_MASK_EN
    input  logic [NUM_CH-1:0] mask,
`endif
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    typedef logic [CH_W:0] w_t;
    localparam w_t NCH = w_t'(NUM_CH);

    // Distance of ch from base walking upward with wrap at NUM_CH.
    function automatic w_t offset(input logic [CH_W-1:0] ch, input logic [CH_W-1:0] base);
        return (ch >= base) ? w_t'(ch) - w_t'(base) : w_t'(ch) + NCH - w_t'(base);
    endfunction

    w_t   len, s, c;
    logic ok;

    // restart searches from first inclusive; otherwise from the slot after cur,
    // stopping at last (not found means the pass has wrapped).
    always_comb begin
        len   = offset(last, first) + w_t'(1);
        s     = restart ? '0 : offset(cur, first) + w_t'(1);
        nxt   = first;
        found = 1'b0;
        c     = '0;
        ok    = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = w_t'(first) + w_t'(k);
            if (c >= NCH) c = c - NCH;
            ok = 1'b1;
`ifdef SCAN_MASK_EN
            ok = mask[c[CH_W-1:0]];
`endif
            if (w_t'(k) >= s && w_t'(k) < len && ok) begin
                nxt   = c[CH_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel scanner for a cascaded analog mux tree: manual/auto modes, break-before-make,
// settle delay and sampler handshake. Define SCAN_MASK_EN to add the ch_mask skip input.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int  LEVELS     = DEF_LEVELS,
    parameter int  SEL_W      = DEF_SEL_W,
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  BBM_CYC    = DEF_BBM_CYC,
    parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    mode,
    input  logic [CH_W-1:0]         man_ch,
    input  logic [CH_W-1:0]         ch_first,
    input  logic [CH_W-1:0]         ch_last,
    output logic [LEVELS*SEL_W-1:0] sel,
    output logic                    mux_en,
    output logic                    sample_req,
    input  logic                    sample_ack,
    output logic [CH_W-1:0]         cur_ch,
    output logic                    busy,
`ifdef SCAN_MASK_EN
    input  logic [NUM_CH-1:0]       ch_mask,
`endif
    output logic                    frame_done
);

    localparam int CNT_MAX = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
    localparam int CNT_W   = clog2_min1(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BBM_LD = CNT_W'(BBM_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CH_W-1:0]  CH_MAX = CH_W'(NUM_CH - 1);

    function automatic logic [CH_W-1:0] clamp(input logic [CH_W-1:0] ch);
        return (ch > CH_MAX) ? CH_MAX : ch;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  cur_q, cur_d, tgt_q, tgt_d, first_q, first_d, last_q, last_d;
    logic             mux_en_q, mux_en_d, req_q, req_d, fd_q, fd_d;
    logic             mode_q, mode_d, stop_q, stop_d;
    logic [CH_W-1:0]  first_in, last_in, man_in, adv_ch, rs_ch, nxt_ch;
    logic             adv_found, rs_found, go, stop_any;

    assign first_in = clamp(ch_first);
    assign last_in  = clamp(ch_last);
    assign man_in   = clamp(man_ch);
    assign stop_any = stop | stop_q;

    // Advance within the latched range, and first eligible channel of the live range.
    mux_scan_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_adv (
        .first(first_q), .last(last_q), .cur(cur_q), .restart(1'b0),
`ifdef SCAN_MASK_EN
        .mask(ch_mask),
`endif
        .nxt(adv_ch), .found(adv_found)
    );

    mux_scan_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rs (
        .first(first_in), .last(last_in), .cur(cur_q), .restart(1'b1),
`ifdef SCAN_MASK_EN
        .mask(ch_mask),
`endif
        .nxt(rs_ch), .found(rs_found)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        mux_en_d = mux_en_q;
        req_d    = req_q;
        fd_d     = 1'b0;
        mode_d   = mode_q;
        first_d  = first_q;
        last_d   = last_q;
        stop_d   = stop_q | stop;
        nxt_ch   = tgt_q;
        go       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start && !stop) begin
                    mode_d  = mode;
                    first_d = first_in;
                    last_d  = last_in;
                    if (!mode) begin
                        nxt_ch = man_in;
                        go     = 1'b1;
                    end else if (rs_found) begin
                        nxt_ch = rs_ch;
                        go     = 1'b1;
                    end else begin
                        fd_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (stop_any) begin
                    state_d  = S_IDLE;
                    mux_en_d = 1'b1;
                    stop_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    cur_d    = tgt_q;
                    mux_en_d = 1'b1;
                    if (SETTLE_CYC == 0) begin
                        state_d = S_SAMPLE;
                        req_d   = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = SET_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (stop_any) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // req re-arms one cycle after an ack when the same channel is resampled
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (sample_ack) begin
                    req_d = 1'b0;
                    if (!mode_q || stop_any) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        fd_d    = !mode_q;
                    end else if (adv_found) begin
                        nxt_ch = adv_ch;
                        go     = 1'b1;
                    end else begin
                        fd_d    = 1'b1;
                        mode_d  = mode;
                        first_d = first_in;
                        last_d  = last_in;
                        if (rs_found) begin
                            nxt_ch = rs_ch;
                            go     = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            tgt_d = nxt_ch;
            if (nxt_ch == cur_q && mux_en_q) begin
                state_d = S_SAMPLE;
                req_d   = (state_q == S_IDLE);
            end else begin
                state_d  = S_BREAK;
                mux_en_d = 1'b0;
                cnt_d    = BBM_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            tgt_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            mux_en_q <= 1'b0;
            req_q    <= 1'b0;
            fd_q     <= 1'b0;
            mode_q   <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            mux_en_q <= mux_en_d;
            req_q    <= req_d;
            fd_q     <= fd_d;
            mode_q   <= mode_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        sel           = '0;
        sel[CH_W-1:0] = cur_q;
    end

    assign cur_ch     = cur_q;
    assign mux_en     = mux_en_q;
    assign sample_req = req_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: channel order, timing and handshake checked against a range/queue model.
module tb_mux_scan_ctrl;

    localparam int LEVELS = 3, SEL_W = 3, NUM_CH = 48, BBM = 2, SETTLE = 8, CH_W = 6;
    localparam int LAT = 1 + BBM + SETTLE;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, sample_ack = 1'b0;
    logic [CH_W-1:0] man_ch = '0, ch_first = '0, ch_last = '0, cur_ch;
    logic [LEVELS*SEL_W-1:0] sel;
    logic mux_en, sample_req, busy, frame_done;
    logic [NUM_CH-1:0] tb_mask = '1;
    int total = 0, bad = 0;
    int cur_m = 0;
    bit en_m = 1'b0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.LEVELS(LEVELS), .SEL_W(SEL_W), .NUM_CH(NUM_CH), .BBM_CYC(BBM),
                    .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .man_ch(man_ch), .ch_first(ch_first), .ch_last(ch_last), .sel(sel),
        .mux_en(mux_en), .sample_req(sample_req), .sample_ack(sample_ack),
        .cur_ch(cur_ch), .busy(busy),
`ifdef SCAN_MASK_EN
        .ch_mask(tb_mask),
`endif
        .frame_done(frame_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int cl(input int x);
        return (x >= NUM_CH) ? NUM_CH - 1 : x;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        total++;
        if ({sel, cur_ch, mux_en, sample_req, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs sel=%0d cur=%0d en=%b req=%b busy=%b fd=%b, want all 0",
                     sel, cur_ch, mux_en, sample_req, busy, frame_done);
        end
        rst_n = 1'b1;
        cur_m = 0;
        en_m  = 1'b0;
    endtask

    task automatic test_manual(input int ch);
        int exp, n, lows;
        bit chg;
        exp = cl(ch);
        chg = (exp != cur_m) || !en_m;
        man_ch = CH_W'(ch);
        mode   = 1'b0;
        start  = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        lows = int'(!mux_en);
        while (!sample_req && n < 100) begin
            tick;
            n++;
            lows += int'(!mux_en);
        end
        total++;
        if (n !== (chg ? LAT : 1)) begin
            bad++;
            $display("FAIL man_latency ch=%0d got=%0d want=%0d", ch, n, chg ? LAT : 1);
        end
        total++;
        if (lows !== (chg ? BBM : 0)) begin
            bad++;
            $display("FAIL man_bbm ch=%0d low_cycles=%0d want=%0d", ch, lows, chg ? BBM : 0);
        end
        total++;
        if (sel !== 9'(exp) || cur_ch !== CH_W'(exp)) begin
            bad++;
            $display("FAIL man_sel ch=%0d sel=%b cur=%0d want=%0d", ch, sel, cur_ch, exp);
        end
        repeat ($urandom_range(0, 2)) tick;
        sample_ack = 1'b1;
        tick;
        sample_ack = 1'b0;
        total++;
        if ({frame_done, busy, sample_req, mux_en} !== 4'b1001 || sel !== 9'(exp)) begin
            bad++;
            $display("FAIL man_done fd/busy/req/en=%b%b%b%b sel=%0d want 1001 sel=%0d",
                     frame_done, busy, sample_req, mux_en, sel, exp);
        end
        tick;
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL man_fd_pulse fd=%b want 0", frame_done);
        end
        cur_m = exp;
        en_m  = 1'b1;
    endtask

    // Scans nsamp samples, then stops on the last one.
    task automatic test_auto(input int first, input int last, input int nsamp);
        int q[$];
        int f, l, c, n, lows, exp;
        bit chg, wrap, fin;
        f = cl(first);
        l = cl(last);
        c = f;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tb_mask[c]) q.push_back(c);
            if (c == l) break;
            c = (c + 1) % NUM_CH;
        end
        ch_first = CH_W'(first);
        ch_last  = CH_W'(last);
        mode     = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        if (q.size() == 0) begin
            total++;
            if ({frame_done, busy, sample_req, mux_en} !== {3'b100, en_m}) begin
                bad++;
                $display("FAIL auto_empty fd/busy/req/en=%b%b%b%b want 100%b",
                         frame_done, busy, sample_req, mux_en, en_m);
            end
            return;
        end
        n = 1;
        lows = int'(!mux_en);
        for (int i = 0; i < nsamp; i++) begin
            exp = q[i % q.size()];
            chg = (exp != cur_m) || !en_m;
            while (!sample_req && n < 100) begin
                tick;
                n++;
                lows += int'(!mux_en);
            end
            total++;
            if (sample_req !== 1'b1 || (chg && n !== LAT) || (!chg && i == 0 && n !== 1)) begin
                bad++;
                $display("FAIL auto_latency idx=%0d ch=%0d req=%b got=%0d chg=%b", i, exp, sample_req, n, chg);
            end
            total++;
            if (lows !== (chg ? BBM : 0)) begin
                bad++;
                $display("FAIL auto_bbm idx=%0d low_cycles=%0d want=%0d", i, lows, chg ? BBM : 0);
            end
            total++;
            if (cur_ch !== CH_W'(exp) || sel !== 9'(exp)) begin
                bad++;
                $display("FAIL auto_order idx=%0d cur=%0d sel=%0d want=%0d", i, cur_ch, sel, exp);
            end
            cur_m = exp;
            en_m  = 1'b1;
            wrap  = ((i % q.size()) == q.size() - 1);
            fin   = (i == nsamp - 1);
            repeat ($urandom_range(0, 3)) tick;
            if (fin) begin
                stop = 1'b1;
                tick;
                stop = 1'b0;
            end
            sample_ack = 1'b1;
            tick;
            sample_ack = 1'b0;
            total++;
            if (fin && (busy !== 1'b0 || sample_req !== 1'b0 || (!wrap && frame_done !== 1'b0))) begin
                bad++;
                $display("FAIL auto_stop busy=%b req=%b fd=%b want 0 0 0", busy, sample_req, frame_done);
            end else if (!fin && (busy !== 1'b1 || sample_req !== 1'b0 || frame_done !== wrap)) begin
                bad++;
                $display("FAIL auto_ack idx=%0d busy=%b req=%b fd=%b want 1 0 %b",
                         i, busy, sample_req, frame_done, wrap);
            end
            n = 1;
            lows = int'(!mux_en);
        end
    endtask

    task automatic test_stop_settle;
        int exp, seen;
        exp = (cur_m + 7) % NUM_CH;
        man_ch = CH_W'(exp);
        mode   = 1'b0;
        start  = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        total++;
        if ({busy, mux_en} !== 2'b01 || sel !== 9'(exp)) begin
            bad++;
            $display("FAIL stop_settle busy=%b en=%b sel=%0d want 0 1 %0d", busy, mux_en, sel, exp);
        end
        seen = 0;
        repeat (15) begin
            tick;
            seen += int'(sample_req | frame_done | busy);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL stop_quiet activity_cycles=%0d want 0", seen);
        end
        cur_m = exp;
        en_m  = 1'b1;
    endtask

    task automatic test_start_stop;
        man_ch = CH_W'((cur_m + 3) % NUM_CH);
        mode   = 1'b0;
        start  = 1'b1;
        stop   = 1'b1;
        tick;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick;
        total++;
        if ({busy, sample_req, mux_en} !== {2'b00, en_m} || cur_ch !== CH_W'(cur_m)) begin
            bad++;
            $display("FAIL start_stop busy=%b req=%b en=%b cur=%0d want 0 0 %b %0d",
                     busy, sample_req, mux_en, cur_ch, en_m, cur_m);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        man_ch = CH_W'((cur_m + 5) % NUM_CH);
        mode   = 1'b0;
        start  = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (!sample_req && n < 100) begin
            tick;
            n++;
        end
        total++;
        if (sample_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_req req=%b after %0d cycles, want 1", sample_req, n);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({sel, cur_ch, mux_en, sample_req, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async sel=%0d cur=%0d en=%b req=%b busy=%b fd=%b, want all 0",
                     sel, cur_ch, mux_en, sample_req, busy, frame_done);
        end
        #2 rst_n = 1'b1;
        tick;
        sample_ack = 1'b1;
        tick;
        sample_ack = 1'b0;
        tick;
        total++;
        if ({sample_req, busy, frame_done, mux_en} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_ack req=%b busy=%b fd=%b en=%b want 0000",
                     sample_req, busy, frame_done, mux_en);
        end
        cur_m = 0;
        en_m  = 1'b0;
    endtask

    initial begin
        int f;
        test_reset;
        test_manual(13);
        test_manual(13);
        for (int i = 0; i < 3; i++) test_manual(int'($urandom_range(0, 63)));
        test_manual(60);
        test_auto(46, 1, 5);
        test_auto(5, 5, 3);
        for (int i = 0; i < 3; i++) begin
            f = int'($urandom_range(0, 63));
            test_auto(f, (cl(f) + int'($urandom_range(0, 4))) % NUM_CH, int'($urandom_range(2, 7)));
        end
        test_stop_settle;
        test_start_stop;
`ifdef SCAN_MASK_EN
        tb_mask = 48'h5;
        test_auto(0, 3, 3);
        tb_mask = '0;
        test_auto(0, 3, 1);
        tb_mask = '1;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Parametrised sequencer driving the select lines of a cascaded analog mux tree with LEVELS stages of 2^SEL_W:1 muxes.
It replaces static select registers with a channel scanner:
- manual single-channel or auto round-robin mode;
- break-before-make switching and a settle delay;
- a request/acknowledge handshake to the downstream ADC sampler.
It sits between the acquisition controller and the board mux address pins.

Parameters:
LEVELS, 3, number of cascaded mux stages (level 0 = bottom stage, select LSBs).
SEL_W, 3, select bits per stage (3 = 8:1 mux).
NUM_CH, 48, number of populated channels (1..2^(LEVELS*SEL_W)).
BBM_CYC, 2, cycles mux_en is held low before the select lines change (>=1).
SETTLE_CYC, 8, cycles after re-enable before sampling (0 allowed).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin operation in the mode given by mode (ignored unless IDLE)
stop  in  1  pulse; end auto scan
mode  in  1  0 = manual single channel, 1 = auto scan
man_ch  in  CH_W  manual channel, CH_W = clog2(NUM_CH)
ch_first  in  CH_W  auto scan first channel
ch_last  in  CH_W  auto scan last channel
sel  out  LEVELS*SEL_W  mux select bus; field k = bits [k*SEL_W +: SEL_W] drives stage k
mux_en  out  1  mux enable (1 = enabled)
sample_req  out  1  channel settled, sample requested
sample_ack  in  1  sampler done
cur_ch  out  CH_W  channel currently selected
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at the end of each auto pass, or at manual completion

Behaviour:
- Reset (async, rst_n=0): sel=0, cur_ch=0, mux_en=0, sample_req=0, busy=0, frame_done=0, state IDLE.
- Channel decode: sel = cur_ch zero-extended to LEVELS*SEL_W; stage k receives bits [k*SEL_W +: SEL_W].
- Out-of-range inputs: any man_ch, ch_first or ch_last >= NUM_CH is clamped to NUM_CH-1.
- States: IDLE, BREAK, SETTLE, SAMPLE.
- IDLE:
  - On start, the target is man_ch (mode=0) or ch_first (mode=1); mode is latched.
  - If target == cur_ch and mux_en=1, go directly to SAMPLE.
  - Otherwise go to BREAK.
- BREAK:
  - mux_en=0 for BBM_CYC cycles.
  - On the last cycle, cur_ch/sel load the target.
  - mux_en returns to 1 on entry to SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles, then enters SAMPLE.
  - If SETTLE_CYC=0, SETTLE is skipped.
- Latency: start to sample_req high = 1 + BBM_CYC + SETTLE_CYC cycles.
- SAMPLE:
  - sample_req=1 is held until sample_ack=1 is seen; it drops on the following cycle.
  - sample_ack while sample_req=0 is ignored.
- After the ack:
  - Manual mode: pulse frame_done and go to IDLE; sel and mux_en stay held.
  - Auto mode: next = cur_ch+1, wrapping NUM_CH-1 -> 0. If cur_ch == ch_last, next = ch_first and frame_done pulses. Then go to BREAK.
- ch_first > ch_last: the scan wraps (ch_first..NUM_CH-1, 0..ch_last).
- ch_first == ch_last: single channel, which is re-sampled every pass without BREAK.
- stop:
  - Latched while busy.
  - In BREAK or SETTLE: go to IDLE next cycle with mux_en=1; sel holds whatever it had at that point.
  - In SAMPLE: the current handshake completes, then go to IDLE.
  - No frame_done is generated by stop.
- start and stop asserted in the same cycle while in IDLE: stop wins, no operation.
- ch_first, ch_last and mode are sampled only at start and at each wrap.

Optional Feature:
- SCAN_MASK_EN defined:
  - Adds input ch_mask[NUM_CH-1:0].
  - Auto mode advances to the next channel with mask=1 within the range.
  - A wrap past ch_last still pulses frame_done.
  - If no channel in the range is unmasked at start or at a wrap: pulse frame_done and go to IDLE with no switching.
  - Manual mode ignores the mask.
- Not defined: no port; every channel in the range is scanned.

Decomposition:
- Package mux_scan_pkg: state enum, clog2 helper for CH_W, default timing constants.
- Sub-module mux_scan_next_ch: combinational next-channel search covering wrap, range and mask.

Test Plan:
- Manual, man_ch=13, defaults -> mux_en low 2 cycles; then sel=9'b000_001_101; sample_req at cycle 11; on ack, frame_done pulses once and busy drops.
- Auto, ch_first=46, ch_last=1 -> channel order 46,47,0,1,46; frame_done pulses on the ack of ch1; BREAK precedes every change.
- Manual re-select of the current channel -> sample_req after 1 cycle; mux_en never deasserted.
- stop during SETTLE (cycle 5 of 8) -> IDLE next cycle; mux_en=1; no sample_req; no frame_done.
- rst_n low mid-SAMPLE -> all outputs return to reset values immediately; a later ack is ignored.
- SCAN_MASK_EN, mask=0x5 over range 0..3 -> channel order 0,2,0; with mask=0 -> immediate frame_done and no mux_en toggle.
